scene_sequencer: RTL and testbench

SCENE_SEQUENCER -- requirements
Module: scene_sequencer

---
 rtl/scene_sequencer.sv | 139 +++++++++++++
 tb/tb_scene_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/scene_sequencer.sv
// Background scene sequencer for a test-pattern generator.
// Steps through NUM_SCENES background scenes, holding each for
// FRAMES_PER_SCENE frames, with manual advance, hold, a per-frame motion
// offset for scrolling scenes and a palette that steps on every full cycle
// through the scene list. All visible state changes only on a frame boundary
// (rising edge of vsync), so outputs are stable for the whole frame.
//
// Inputs vsync, next_req and hold are plain levels synchronous to clk; there
// is no valid/ready handshake on this block.
module scene_sequencer #(
    parameter int FRAMES_PER_SCENE = 120,
    parameter int NUM_SCENES       = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       next_req,
    input  logic       hold,
    output logic [3:0] scene,
    output logic [5:0] solid_color,
    output logic [9:0] motion,
    output logic       scene_start
);

    // Last dwell count before an automatic advance, and the last scene index.
    localparam logic [9:0] DWELL_LAST = 10'(FRAMES_PER_SCENE - 1);
    localparam logic [3:0] SCENE_LAST = 4'(NUM_SCENES - 1);

    // Palette index to {R,G,B} colour, two bits per channel.
    function automatic logic [5:0] palette_color(input logic [2:0] idx);
        logic [5:0] c;
        case (idx)
            3'd0:    c = 6'b110000;
            3'd1:    c = 6'b001100;
            3'd2:    c = 6'b000011;
            3'd3:    c = 6'b111100;
            3'd4:    c = 6'b110011;
            3'd5:    c = 6'b001111;
            3'd6:    c = 6'b111111;
            default: c = 6'b010101;
        endcase
        return c;
    endfunction

    // Edge-detect history; reset to 1 so a level already high at reset
    // release is not mistaken for a fresh edge.
    logic       vsync_d;
    logic       next_req_d;

    // Internal sequencing state.
    logic       pending;
    logic [9:0] dwell;
    logic [2:0] palette_idx;

    // Next-state values.
    logic       pending_nxt;
    logic [9:0] dwell_nxt;
    logic [2:0] palette_nxt;
    logic [3:0] scene_nxt;
    logic [9:0] motion_nxt;

    // Decoded events for the current cycle.
    logic       frame_tick;
    logic       req_edge;
    logic       dwell_expire;
    logic       advance;

    // Event decode: frame boundary, manual request edge, and whether this
    // boundary moves to the next scene (manual and automatic merge into one).
    always_comb begin
        frame_tick   = vsync & ~vsync_d;
        req_edge     = next_req & ~next_req_d;
        dwell_expire = frame_tick & ~hold & (dwell == DWELL_LAST);
        advance      = frame_tick & (pending | dwell_expire);
    end

    // Next-state computation for scene, dwell, motion, palette and pending.
    always_comb begin
        scene_nxt   = scene;
        dwell_nxt   = dwell;
        motion_nxt  = motion;
        palette_nxt = palette_idx;

        if (frame_tick) begin
            motion_nxt = motion + 10'd1;
            if (!hold) begin
                dwell_nxt = dwell_expire ? 10'd0 : dwell + 10'd1;
            end
            if (advance) begin
                dwell_nxt  = 10'd0;
                motion_nxt = 10'd0;
                if (scene == SCENE_LAST) begin
                    scene_nxt   = 4'd0;
                    palette_nxt = palette_idx + 3'd1;
                end else begin
                    scene_nxt = scene + 4'd1;
                end
            end
        end

        // A tick consumes the request that was already waiting; an edge in
        // the same cycle survives to be served by the following tick.
        pending_nxt = req_edge | (pending & ~frame_tick);
    end

    // Edge-detect history registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_d    <= 1'b1;
            next_req_d <= 1'b1;
        end else begin
            vsync_d    <= vsync;
            next_req_d <= next_req;
        end
    end

    // Sequencing state and registered outputs; reset discards any pending
    // request and overrides a coincident tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scene       <= 4'd0;
            dwell       <= 10'd0;
            motion      <= 10'd0;
            palette_idx <= 3'd0;
            solid_color <= 6'b110000;
            pending     <= 1'b0;
            scene_start <= 1'b0;
        end else begin
            scene       <= scene_nxt;
            dwell       <= dwell_nxt;
            motion      <= motion_nxt;
            palette_idx <= palette_nxt;
            solid_color <= palette_color(palette_nxt);
            pending     <= pending_nxt;
            scene_start <= advance;
        end
    end

endmodule

// File: tb/tb_scene_sequencer.sv
// Directed bench for scene_sequencer with FRAMES_PER_SCENE=4, NUM_SCENES=11.
module tb_scene_sequencer;

    localparam int FPS = 4;
    localparam int NS  = 11;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic       vsync;
    logic       next_req;
    logic       hold;
    logic [3:0] scene;
    logic [5:0] solid_color;
    logic [9:0] motion;
    logic       scene_start;

    always #5 clk = ~clk;

    scene_sequencer #(
        .FRAMES_PER_SCENE(FPS),
        .NUM_SCENES      (NS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .next_req   (next_req),
        .hold       (hold),
        .scene      (scene),
        .solid_color(solid_color),
        .motion     (motion),
        .scene_start(scene_start)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int start_cnt = 0;
    logic tick_start;
    logic post_start;

    logic [5:0] pal_tab [8];
    initial begin
        pal_tab[0] = 6'b110000; pal_tab[1] = 6'b001100;
        pal_tab[2] = 6'b000011; pal_tab[3] = 6'b111100;
        pal_tab[4] = 6'b110011; pal_tab[5] = 6'b001111;
        pal_tab[6] = 6'b111111; pal_tab[7] = 6'b010101;
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Count scene_start pulses, sampled away from the active edge.
    always @(negedge clk) if (scene_start === 1'b1) start_cnt++;

    // ---------------- driver tasks ----------------
    // One frame: vsync rises, tick happens at the next edge, then low time.
    task automatic do_frame(input logic nreq);
        @(posedge clk); #1;
        vsync = 1'b1;
        if (nreq) next_req = 1'b1;
        @(posedge clk); #1;
        tick_start = scene_start;
        if (nreq) next_req = 1'b0;
        @(posedge clk); #1;
        post_start = scene_start;
        vsync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) do_frame(1'b0);
    endtask

    // Manual request pulse in the middle of a frame (vsync low).
    task automatic pulse_req();
        @(posedge clk); #1 next_req = 1'b1;
        @(posedge clk); #1 next_req = 1'b0;
        @(posedge clk); #1;
    endtask

    int c0;

    initial begin
        // Reset with vsync and next_req already high.
        rst_n = 1'b0; vsync = 1'b1; next_req = 1'b1; hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_scene", 16'(scene), 16'd0);
        check_eq("rst_motion", 16'(motion), 16'd0);
        check_eq("rst_color", 16'(solid_color), 16'(6'b110000));
        check_eq("rst_start", 16'(scene_start), 16'd0);

        // Release with vsync held high for 3 cycles: no tick.
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rel_scene", 16'(scene), 16'd0);
        check_eq("rel_motion", 16'(motion), 16'd0);
        check_eq("rel_color", 16'(solid_color), 16'(6'b110000));
        vsync = 1'b0; next_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rel_motion2", 16'(motion), 16'd0);
        check_eq("rel_starts", 16'(start_cnt), 16'd0);

        // Auto advance after 4 frames.
        do_frame(1'b0); check_eq("a_m1", 16'(motion), 16'd1);
        do_frame(1'b0); check_eq("a_m2", 16'(motion), 16'd2);
        do_frame(1'b0); check_eq("a_m3", 16'(motion), 16'd3);
        check_eq("a_s3", 16'(scene), 16'd0);
        do_frame(1'b0);
        check_eq("a_scene", 16'(scene), 16'd1);
        check_eq("a_motion", 16'(motion), 16'd0);
        check_eq("a_start_hi", 16'(tick_start), 16'd1);
        check_eq("a_start_lo", 16'(post_start), 16'd0);
        check_eq("a_starts", 16'(start_cnt), 16'd1);

        // Manual request during frame 3 coinciding with dwell expiry.
        frames(3);
        check_eq("b_m3", 16'(motion), 16'd3);
        pulse_req();
        check_eq("b_midframe", 16'(scene), 16'd1);
        c0 = start_cnt;
        do_frame(1'b0);
        check_eq("b_scene", 16'(scene), 16'd2);
        check_eq("b_motion", 16'(motion), 16'd0);
        check_eq("b_one_pulse", 16'(start_cnt - c0), 16'd1);
        frames(3);
        check_eq("b_dwell_hold", 16'(scene), 16'd2);
        check_eq("b_m3b", 16'(motion), 16'd3);
        do_frame(1'b0);
        check_eq("b_next", 16'(scene), 16'd3);

        // Early manual advance restarts the dwell.
        do_frame(1'b0);
        pulse_req();
        do_frame(1'b0);
        check_eq("c_scene", 16'(scene), 16'd4);
        check_eq("c_motion", 16'(motion), 16'd0);
        frames(3);
        check_eq("c_stay", 16'(scene), 16'd4);
        do_frame(1'b0);
        check_eq("c_next", 16'(scene), 16'd5);

        // Reset while a request is pending at scene 5.
        pulse_req();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        check_eq("d_scene", 16'(scene), 16'd0);
        check_eq("d_motion", 16'(motion), 16'd0);
        check_eq("d_color", 16'(solid_color), 16'(6'b110000));
        check_eq("d_start", 16'(scene_start), 16'd0);
        do_frame(1'b0);
        check_eq("d_noadv", 16'(scene), 16'd0);
        check_eq("d_motion1", 16'(motion), 16'd1);
        check_eq("d_nostart", 16'(tick_start), 16'd0);

        // Request edge in the same cycle as the tick.
        pulse_req();
        do_frame(1'b1);
        check_eq("e_scene1", 16'(scene), 16'd1);
        check_eq("e_motion1", 16'(motion), 16'd0);
        do_frame(1'b0);
        check_eq("e_scene2", 16'(scene), 16'd2);
        check_eq("e_motion2", 16'(motion), 16'd0);
        check_eq("e_start2", 16'(tick_start), 16'd1);

        // Hold for 200 frames, then a manual request.
        hold = 1'b1;
        c0 = start_cnt;
        frames(200);
        check_eq("h_scene", 16'(scene), 16'd2);
        check_eq("h_motion", 16'(motion), 16'd200);
        check_eq("h_starts", 16'(start_cnt - c0), 16'd0);
        pulse_req();
        check_eq("h_midframe", 16'(scene), 16'd2);
        do_frame(1'b0);
        check_eq("h_adv", 16'(scene), 16'd3);
        check_eq("h_motion0", 16'(motion), 16'd0);
        do_frame(1'b0);
        check_eq("h_stay", 16'(scene), 16'd3);
        check_eq("h_motion1", 16'(motion), 16'd1);
        hold = 1'b0;

        // Walk to the wrap 10 -> 0 and through all palette entries.
        frames(31);
        check_eq("w_scene10", 16'(scene), 16'd10);
        check_eq("w_color0", 16'(solid_color), 16'(6'b110000));
        do_frame(1'b0);
        check_eq("w_scene0", 16'(scene), 16'd0);
        check_eq("w_color1", 16'(solid_color), 16'(6'b001100));
        check_eq("w_start", 16'(tick_start), 16'd1);
        for (int k = 0; k < 7; k++) begin
            frames(NS * FPS);
            check_eq("w_pal", 16'(solid_color), 16'(pal_tab[(k + 2) % 8]));
            check_eq("w_pal_scene", 16'(scene), 16'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
